// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM, IF/ID pipeline register,
// a one-entry hold buffer for responses that arrive under a decode stall, and redirect/flush handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        iClkCPU,
  input  logic        iRST,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic [31:0] iIMemRdata,
  input  logic        iIMemValid,
  output logic [31:0] oInstruction,
  output logic [31:0] oPC_ID,
  output logic [31:0] oPC4_ID,
  output logic        oValid_ID,
  output logic [31:0] oPCView
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = {iRedirectPC[XLEN-1:2], 2'b00};
  assign oPCView         = pc;

  // oIMemReq is registered, so the request is visible the cycle after REQ: REQ, WAIT, WAIT+response.
  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      hold_instr   <= '0;
      hold_pc      <= '0;
      oIMemReq     <= 1'b0;
      oIMemAddr    <= '0;
      oInstruction <= '0;
      oPC_ID       <= '0;
      oPC4_ID      <= '0;
      oValid_ID    <= 1'b0;
    end else begin
      oIMemReq <= 1'b0;
      if (iRedirect) begin
        pc           <= redirect_target;
        oInstruction <= '0;
        oPC_ID       <= '0;
        oPC4_ID      <= '0;
        oValid_ID    <= 1'b0;
        case (state)
          ST_REQ: begin
            // The request still goes out; DRAIN absorbs its response.
            oIMemReq  <= 1'b1;
            oIMemAddr <= pc;
            state     <= ST_DRAIN;
          end
          ST_WAIT:  state <= iIMemValid ? ST_REQ : ST_DRAIN;
          ST_HOLD:  state <= ST_REQ;
          ST_DRAIN: state <= iIMemValid ? ST_REQ : ST_DRAIN;
          default:  state <= ST_REQ;
        endcase
      end else begin
        if (iFlush) begin
          oInstruction <= '0;
          oPC_ID       <= '0;
          oPC4_ID      <= '0;
          oValid_ID    <= 1'b0;
        end
        case (state)
          ST_REQ: begin
            oIMemReq  <= 1'b1;
            oIMemAddr <= pc;
            state     <= ST_WAIT;
          end
          ST_WAIT: begin
            if (iIMemValid) begin
              if (iStall) begin
                hold_instr <= iIMemRdata;
                hold_pc    <= pc;
                state      <= ST_HOLD;
              end else begin
                if (!iFlush) begin
                  oInstruction <= iIMemRdata;
                  oPC_ID       <= pc;
                  oPC4_ID      <= pc + INSN_BYTES;
                  oValid_ID    <= 1'b1;
                end
                pc    <= pc + INSN_BYTES;
                state <= ST_REQ;
              end
            end
          end
          ST_HOLD: begin
            if (!iStall) begin
              if (!iFlush) begin
                oInstruction <= hold_instr;
                oPC_ID       <= hold_pc;
                oPC4_ID      <= hold_pc + INSN_BYTES;
                oValid_ID    <= 1'b1;
              end
              pc    <= pc + INSN_BYTES;
              state <= ST_REQ;
            end
          end
          ST_DRAIN: begin
            if (iIMemValid) state <= ST_REQ;
          end
          default: state <= ST_REQ;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, address of the first instruction fetched after reset.
REQ-002 iClkCPU  input  1  CPU clock; all state changes on its rising edge.
REQ-003 iRST  input  1  asynchronous, active-high reset.
REQ-004 iStall  input  1  hazard hold from decode: freeze PC and the IF/ID register.
REQ-005 iFlush  input  1  squash the IF/ID register.
REQ-006 iRedirect  input  1  taken branch/jump: load a new PC.
REQ-007 iRedirectPC  input  32  redirect target.
REQ-008 oIMemReq  output  1  one-cycle fetch request pulse.
REQ-009 oIMemAddr  output  32  fetch address, valid while oIMemReq=1.
REQ-010 iIMemRdata  input  32  instruction word, valid while iIMemValid=1.
REQ-011 iIMemValid  input  1  response strobe; at least 1 cycle after the request, at most one request outstanding.
REQ-012 oInstruction  output  32  IF/ID instruction word, fed to control and decode.
REQ-013 oPC_ID  output  32  IF/ID PC of oInstruction.
REQ-014 oPC4_ID  output  32  IF/ID oPC_ID+4.
REQ-015 oValid_ID  output  1  IF/ID holds a live instruction.
REQ-016 oPCView  output  32  current fetch PC, for board display.

Function
REQ-017 The stage SHALL implement the FSM states REQ, WAIT, HOLD and DRAIN.
REQ-018 REQ: the stage SHALL drive oIMemReq=1 and oIMemAddr=PC for exactly one cycle, then go to WAIT (DRAIN if iRedirect=1).
REQ-019 WAIT with iIMemValid=1 and iStall=0: at the edge, IF/ID SHALL load {iIMemRdata, PC, PC+4, valid=1}, PC SHALL become PC+4 (mod 2^32), and the FSM SHALL go to REQ.
REQ-020 WAIT with iIMemValid=1 and iStall=1: iIMemRdata and PC SHALL be captured in a one-entry hold buffer, IF/ID SHALL be unchanged, and the FSM SHALL go to HOLD.
REQ-021 HOLD: oIMemReq=0; on the first cycle with iStall=0, IF/ID SHALL load the buffer, PC SHALL become PC+4, and the FSM SHALL go to REQ.
REQ-022 DRAIN: the stage SHALL wait for iIMemValid, discard the data without altering IF/ID or PC, then go to REQ.
REQ-023 Best-case throughput SHALL be one instruction per 3 cycles; the response latency SHALL be counted from the WAIT entry.
REQ-024 Priority SHALL be iRedirect > iFlush > iStall.
REQ-025 iRedirect=1: PC SHALL load {iRedirectPC[31:2], 2'b00}, and IF/ID SHALL clear (oValid_ID=0, oInstruction=0).
REQ-026 Redirect FSM transitions:
- REQ or WAIT without iIMemValid -> DRAIN.
- WAIT with iIMemValid (response consumed and discarded) -> REQ.
- HOLD (buffer discarded) -> REQ.
- DRAIN with iIMemValid -> REQ; DRAIN without iIMemValid -> stays in DRAIN.
REQ-027 iFlush=1 without iRedirect SHALL clear IF/ID next edge, even under iStall; PC, the FSM and the hold buffer SHALL proceed as if iFlush were 0 except that a response accepted that cycle SHALL NOT enter IF/ID.
REQ-028 iStall=1 in REQ or DRAIN SHALL NOT block the request or the drain; PC SHALL advance only on the IF/ID loads of REQ-019 and REQ-021.
REQ-029 oPCView SHALL equal the PC register combinationally.
REQ-030 iIMemValid in REQ or HOLD is a protocol violation, SHALL be ignored, and SHALL NOT change state.

Reset
REQ-031 While iRST=1, the stage SHALL hold: PC=RESET_PC, oInstruction=0, oPC_ID=0, oPC4_ID=0, oValid_ID=0, hold buffer cleared, FSM=REQ, oIMemReq=0.
REQ-032 Reset mid-fetch SHALL abandon the outstanding request; the first edge after deassert SHALL issue a request to RESET_PC.

Verification
REQ-033 Reset release, memory returns 32'h00500093 one cycle after the request -> IF/ID = {00500093, 00400000, 00400004, 1}; next request address is 00400004.
REQ-034 iStall=1 for 4 cycles as a response arrives -> IF/ID frozen and no oIMemReq; on release IF/ID gets the buffered word and PC advances by 4.
REQ-035 iRedirect=1, iRedirectPC=32'h0040_0103 in WAIT with memory latency 3 -> next IF/ID valid=0, stale word dropped, next request address 00400100.
REQ-036 iFlush=1 on the same cycle as an accepted response -> oValid_ID=0, oInstruction=0, PC advanced by 4.
REQ-037 PC=32'hFFFF_FFFC fetched with no stall -> oPC4_ID=0 and next PC=0.
REQ-038 iRST asserted during DRAIN -> all outputs reach their reset values without waiting for a clock edge.
